mdd_apb4_bridge: RTL
====================

// Module: mdd_apb4_bridge
// PURPOSE
//  Upstream master for the MDD APB4 segment: converts the core's native valid/ready memory request
//  into APB4 SETUP/ACCESS transfers and drives the apb4_if consumed by the MDD wrapper.
//  Handles one outstanding transfer and returns read data, write completion and slave error.
// PARAMETERS
//  ADDR_WIDTH      32    native/APB address width
//  DATA_WIDTH      32    data width; fixed 32, strobe width DATA_WIDTH/8
//  PPROT_VAL       3'b000  constant driven on pprot
//  TIMEOUT_CYCLES  255   ACCESS-phase wait limit, only when MDD_APB4_TIMEOUT_EN
// PORTS
//  clk_i        in   1   single clock, all logic rising-edge
//  rst_i        in   1   asynchronous, active-high reset
//  mem_valid_i  in   1   request valid; held by core until mem_ready_o
//  mem_addr_i   in   ADDR_WIDTH  byte address
//  mem_wdata_i  in   32  write data
//  mem_wstrb_i  in   4   byte strobes; 0 = read
//  mem_ready_o  out  1   one-cycle completion pulse
//  mem_rdata_o  out  32  read data, valid while mem_ready_o
//  err_o        out  1   slave error/timeout, one-cycle, coincident with mem_ready_o
//  apb          apb4_if.master  drives paddr,pprot,psel,penable,pwrite,pwdata,pstrb; samples pready,prdata,pslverr
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; psel,penable,pwrite,mem_ready_o,err_o=0; paddr,pwdata,pstrb,mem_rdata_o=0.
//  FSM IDLE->SETUP->ACCESS->RESP->IDLE, encoded state register, registered outputs.
//  IDLE: if mem_valid_i, latch addr/wdata/wstrb -> SETUP. Else stay; no APB activity.
//  SETUP (1 cycle): psel=1, penable=0, paddr={addr[AW-1:2],2'b00}, pwrite=|wstrb,
//    pwdata=wdata, pstrb=pwrite?wstrb:4'h0, pprot=PPROT_VAL -> ACCESS.
//  ACCESS: psel=1, penable=1, all fields stable. pready=1: capture prdata (reads), pslverr -> RESP;
//    pready=0: stay.
//  RESP (1 cycle): psel=penable=0; mem_ready_o=1; mem_rdata_o=prdata if read & !err else 0; err_o=captured err.
//  RESP always returns to IDLE, even when mem_valid_i is still high. Core drops valid the cycle after ready.
//  Minimum latency: valid sampled at edge N, ready high in cycle N+3 with zero-wait slave. Each pready wait cycle adds one.
//  mem_* inputs are ignored outside IDLE; changes mid-transfer have no effect.
//  Write with pslverr: ready+err_o, write is not retried.
//  Back-to-back requests: each costs >=4 cycles, since IDLE is re-entered between transfers.
//  Reset asserted mid-ACCESS: psel/penable drop asynchronously, no mem_ready_o pulse, transfer is lost.
// CONFIGURATION
//  `MDD_APB4_TIMEOUT_EN, defined in mdd_config.svh:
//    defined: a counter clears on SETUP and increments each ACCESS cycle with pready=0.
//      Reaching TIMEOUT_CYCLES forces RESP with err_o=1 and mem_rdata_o=32'hFFFF_FFFF.
//      psel/penable drop. A late pready is ignored.
//    undefined: no counter, ACCESS waits indefinitely, TIMEOUT_CYCLES unused.
// STRUCTURE
//  mdd_apb4_bridge_pkg: state enum (IDLE,SETUP,ACCESS,RESP), MDD_APB4_TMO_RDATA=32'hFFFF_FFFF, strobe width.
//  Sub-module mdd_apb4_tmo_cnt: clear/inc/expire counter, instantiated only under MDD_APB4_TIMEOUT_EN.
//  Upstream of ip_mdd_wrapper's apb port. sel_i decode is outside this block.
// TESTING
//  Read 0x0000_0010, slave pready=1, prdata=0xA5A5_1234 -> psel cycle N+1, penable N+2, mem_ready_o N+3 with rdata 0xA5A5_1234, err_o=0.
//  Write addr 0x13 wdata 0xCAFE_F00D wstrb 4'b0110 -> paddr 0x10, pwrite=1, pstrb 4'b0110, pwdata stable across SETUP/ACCESS.
//  Read with 3 wait states -> penable held 4 cycles, ready at N+6. Read with pslverr=1 -> err_o=1, rdata 0.
//  Assert rst_i in ACCESS -> psel/penable 0 same cycle, no ready pulse. Next request after release completes normally.
//  With MDD_APB4_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready stuck 0 -> ready+err_o after 8 ACCESS cycles, rdata 0xFFFF_FFFF.
//  Same stimulus without the macro -> bridge still in ACCESS after 1000 cycles.
//  Assertions: APB4 stability (fields constant SETUP->ACCESS); pstrb==0 on reads; at most one ready per valid.

Source files
------------

// File: rtl/mdd_apb4_bridge_pkg.sv
// -----------------------------------------------------------------------------
// mdd_apb4_bridge_pkg
// Shared definitions for the MDD APB4 upstream bridge:
//   - mdd_apb4_state_e   : bridge FSM states (IDLE, SETUP, ACCESS, RESP)
//   - MDD_APB4_TMO_RDATA : read data returned when an ACCESS phase times out
//   - MDD_APB4_STRB_W    : byte-strobe width of the 32-bit data path
// -----------------------------------------------------------------------------
package mdd_apb4_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } mdd_apb4_state_e;

    localparam logic [31:0] MDD_APB4_TMO_RDATA = 32'hFFFF_FFFF;
    localparam int          MDD_APB4_STRB_W    = 32 / 8;

endpackage

// File: rtl/apb4_if.sv
// -----------------------------------------------------------------------------
// apb4_if
// APB4 bus bundle between the MDD bridge (master) and the MDD wrapper (slave).
//   master modport: drives paddr, pprot, psel, penable, pwrite, pwdata, pstrb;
//                   samples pready, prdata, pslverr
//   slave modport : the mirror image
// -----------------------------------------------------------------------------
interface apb4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/mdd_apb4_tmo_cnt.sv
// -----------------------------------------------------------------------------
// mdd_apb4_tmo_cnt
// ACCESS-phase wait counter for the MDD APB4 bridge. The module body exists
// only when MDD_APB4_TIMEOUT_EN is defined (normally from mdd_config.svh);
// without it the bridge has no timeout and this file is empty.
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset
//   clr_i    : restart the count (bridge in SETUP)
//   inc_i    : one more ACCESS cycle without pready
//   expire_o : combinational; high on the increment that reaches LIMIT
// -----------------------------------------------------------------------------
`ifdef MDD_APB4_TIMEOUT_EN
module mdd_apb4_tmo_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count holds the number of stalled cycles already seen, so the
    // LIMIT-th stalled cycle is the one where cnt_q == LIMIT-1.
    assign expire_o = inc_i && (cnt_q == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule
`endif

// File: rtl/mdd_apb4_bridge.sv
// -----------------------------------------------------------------------------
// mdd_apb4_bridge
// Upstream APB4 master for the MDD segment. Turns one native valid/ready
// memory request at a time into an APB4 SETUP/ACCESS transfer and returns
// read data, write completion and slave error to the core.
//
// Optional feature: MDD_APB4_TIMEOUT_EN (normally set in mdd_config.svh).
//   defined  : ACCESS is abandoned after TIMEOUT_CYCLES stalled cycles,
//              completing with err_o=1 and mem_rdata_o=32'hFFFF_FFFF.
//   undefined: ACCESS waits for pready indefinitely.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   mem_valid_i  : request valid, held until mem_ready_o
//   mem_addr_i   : byte address (word-aligned onto paddr)
//   mem_wdata_i  : write data
//   mem_wstrb_i  : byte strobes, all-zero means read
//   mem_ready_o  : one-cycle completion pulse
//   mem_rdata_o  : read data, valid with mem_ready_o
//   err_o        : slave error / timeout, coincident with mem_ready_o
//   apb          : APB4 master port
// -----------------------------------------------------------------------------
module mdd_apb4_bridge
    import mdd_apb4_bridge_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [2:0]  PPROT_VAL      = 3'b000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mem_valid_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i,
    output logic                    mem_ready_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    err_o,
    apb4_if.master                  apb
);
    mdd_apb4_state_e state_q;
    logic            tmo_expire;

    // Byte offset is dropped: APB transfers are always word aligned.
    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = mem_addr_i[1:0];

    assign apb.pprot = PPROT_VAL;

`ifdef MDD_APB4_TIMEOUT_EN
    logic tmo_clr;
    logic tmo_inc;

    assign tmo_clr = (state_q == ST_SETUP);
    assign tmo_inc = (state_q == ST_ACCESS) && !apb.pready;

    mdd_apb4_tmo_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (tmo_clr),
        .inc_i    (tmo_inc),
        .expire_o (tmo_expire)
    );
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign tmo_expire            = 1'b0;
`endif

    // All APB and core-side outputs are registered: each transition sets the
    // outputs that belong to the state being entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            apb.pstrb   <= '0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_valid_i) begin
                        apb.psel    <= 1'b1;
                        apb.penable <= 1'b0;
                        apb.paddr   <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        apb.pwrite  <= |mem_wstrb_i;
                        apb.pwdata  <= mem_wdata_i;
                        apb.pstrb   <= (|mem_wstrb_i) ? mem_wstrb_i : '0;
                        state_q     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    apb.penable <= 1'b1;
                    state_q     <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (apb.pready) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        mem_ready_o <= 1'b1;
                        err_o       <= apb.pslverr;
                        mem_rdata_o <= (!apb.pwrite && !apb.pslverr) ? apb.prdata : '0;
                        state_q     <= ST_RESP;
                    end else if (tmo_expire) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        mem_ready_o <= 1'b1;
                        err_o       <= 1'b1;
                        mem_rdata_o <= DATA_WIDTH'(MDD_APB4_TMO_RDATA);
                        state_q     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // Always fall back to IDLE so a still-high valid from the
                    // finished request is never taken as a new one.
                    mem_ready_o <= 1'b0;
                    err_o       <= 1'b0;
                    mem_rdata_o <= '0;
                    state_q     <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
